// File: rtl/demux_frame_assembler_if.sv
// Bus between the 1:32 demux qualifiers and the frame assembler.
// Drop counter signals exist only when OVERFLOW_CNT_EN is defined.
interface demux_frame_assembler_if #(
    parameter int CHANNELS = 32,
    parameter int SEL_W    = 5
);
    logic                enable;
    logic [SEL_W-1:0]    select;
    logic [CHANNELS-1:0] channel;
    logic                flush;
    logic                word_ready;
    logic [CHANNELS-1:0] word;
    logic                word_valid;
    logic                busy;
    logic [SEL_W:0]      fill_count;
    logic                dup_error;
`ifdef OVERFLOW_CNT_EN
    logic [7:0]          drop_count;

    modport master (
        output enable, select, channel, flush, word_ready,
        input  word, word_valid, busy, fill_count, dup_error, drop_count
    );
    modport slave (
        input  enable, select, channel, flush, word_ready,
        output word, word_valid, busy, fill_count, dup_error, drop_count
    );
`else
    modport master (
        output enable, select, channel, flush, word_ready,
        input  word, word_valid, busy, fill_count, dup_error
    );
    modport slave (
        input  enable, select, channel, flush, word_ready,
        output word, word_valid, busy, fill_count, dup_error
    );
`endif
endinterface

// File: rtl/demux_frame_assembler.sv
// Reassembles scattered single-bit demux writes into a parallel word with valid/ready output.
// Optional saturating drop counter enabled by defining OVERFLOW_CNT_EN.

// One channel of the frame: data bit plus "written this frame" mask bit.
module dfa_lane (
    input  logic gclk,
    input  logic grst_n,
    input  logic wr,
    input  logic clr,
    input  logic din,
    output logic q,
    output logic m
);
    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            q <= 1'b0;
            m <= 1'b0;
        end else begin
            if (wr)
                q <= din;
            // A write in the clearing cycle becomes the first bit of the new frame
            if (clr)
                m <= wr;
            else if (wr)
                m <= 1'b1;
        end
    end
endmodule

module demux_frame_assembler #(
    parameter int CHANNELS = 32,
    parameter int SEL_W    = 5
) (
    input logic                  gclk,
    input logic                  grst_n,
    demux_frame_assembler_if.slave bus
);
    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_HOLD    = 1'b1;

    logic [0:0]          state;
    logic [CHANNELS-1:0] word_q;
    logic [CHANNELS-1:0] mask;
    logic [CHANNELS-1:0] wr_lane;
    logic [CHANNELS-1:0] mask_nxt;
    logic [SEL_W:0]      fill;
    logic                in_range;
    logic                accept;
    logic                xfer;
    logic                clr;
    logic                dup_hit;
    logic                dup_q;

    assign bus.busy = (state == S_HOLD) & ~bus.word_ready;
    assign in_range = ({1'b0, bus.select} < (SEL_W+1)'(CHANNELS));
    assign accept   = bus.enable & ~bus.busy & ~bus.flush;
    assign xfer     = (state == S_HOLD) & bus.word_ready;
    assign clr      = bus.flush | xfer;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign wr_lane[gi] = accept & in_range & (bus.select == SEL_W'(gi));
            dfa_lane u_lane (
                .gclk   (gclk),
                .grst_n (grst_n),
                .wr     (wr_lane[gi]),
                .clr    (clr),
                .din    (bus.channel[gi]),
                .q      (word_q[gi]),
                .m      (mask[gi])
            );
        end
    endgenerate

    assign mask_nxt = clr ? wr_lane : (mask | wr_lane);
    // In HOLD the only accepted write is the transfer-cycle one, which starts a fresh mask
    assign dup_hit  = accept & (~in_range | ((state == S_COLLECT) & (|(wr_lane & mask))));

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            state <= S_COLLECT;
        end else begin
            case (state)
                S_COLLECT: if (&mask_nxt) state <= S_HOLD;
                S_HOLD:    if (clr) state <= S_COLLECT;
                default:   state <= S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge gclk) begin
        if (!grst_n)
            dup_q <= 1'b0;
        else if (bus.flush)
            dup_q <= 1'b0;
        else if (dup_hit)
            dup_q <= 1'b1;
    end

    always_comb begin
        fill = '0;
        for (int i = 0; i < CHANNELS; i++)
            fill = fill + {{SEL_W{1'b0}}, mask[i]};
    end

`ifdef OVERFLOW_CNT_EN
    logic [7:0] drop_q;
    always_ff @(posedge gclk) begin
        if (!grst_n)
            drop_q <= 8'd0;
        else if (bus.enable & bus.busy & (drop_q != 8'hFF))
            drop_q <= drop_q + 8'd1;
    end
    assign bus.drop_count = drop_q;
`endif

    assign bus.word       = word_q;
    assign bus.word_valid = (state == S_HOLD);
    assign bus.fill_count = fill;
    assign bus.dup_error  = dup_q;
endmodule

// File: doc/demux_frame_assembler.md
# demux_frame_assembler

Downstream companion to the 1:32 demultiplexer. Consumes the demux's 32 routed outputs (as one bus) plus the same enable/select qualifiers that drive the demux. It reassembles the scattered single-bit writes into one parallel word and presents each completed word on a valid/ready output. Duplicate, dropped and out-of-range writes are flagged.

## Interface
- CHANNELS, 32, number of demux channels per frame; power of two, 2..32
- SEL_W, 5, select width; must equal log2(CHANNELS)
- Clock_In  input  1  single clock; all logic on rising edge
- Reset_n_In  input  1  reset, synchronous, active-low
- Enable_In  input  1  write strobe, same signal that enables the demux
- Select_In  input  SEL_W  channel being written, same value as the demux select
- Channel_In  input  CHANNELS  demux outputs, bit i = Data_i_Out
- Flush_In  input  1  synchronous abort of the partial frame
- Word_Ready_In  input  1  downstream accepts the word
- Word_Out  output  CHANNELS  assembled word, bit i = last value written to channel i
- Word_Valid_Out  output  1  word complete and held
- Busy_Out  output  1  combinational; Word_Valid_Out & ~Word_Ready_In
- Fill_Count_Out  output  SEL_W+1  number of distinct channels written in the current frame
- Dup_Error_Out  output  1  sticky; a channel was written twice in one frame
- Drop_Count_Out  output  8  only with OVERFLOW_CNT_EN; saturating count of dropped writes

## Operation
- State machine, two states:
  - COLLECT: accepts writes.
  - HOLD: complete word presented.
- A write is a cycle with Enable_In=1 and Busy_Out=0.
  - Captures Channel_In[Select_In] into word bit Select_In.
  - Sets mask bit Select_In.
  - Fill_Count_Out is the popcount of the mask.
- Writing a channel whose mask bit is already set:
  - The data bit is overwritten.
  - Fill_Count_Out is unchanged.
  - Dup_Error_Out is set.
- Mask becomes all-ones: go to HOLD and assert Word_Valid_Out. Word_Out is frozen while in HOLD.
- Handshake: a word transfers on a rising edge where Word_Valid_Out=1 and Word_Ready_In=1.
  - On transfer: mask cleared, Fill_Count_Out=0, return to COLLECT.
  - Word_Out keeps the old value until it is overwritten bit by bit.
- A write presented in the transfer cycle is accepted and counts as the first write of the new frame. Busy_Out is 0 in that cycle.
- A write with Busy_Out=1 is dropped. Word, mask and state are unchanged.
- Out-of-range Select_In (>= CHANNELS, reachable only when CHANNELS<32 and SEL_W is oversized): write ignored, Dup_Error_Out set.
- Flush_In=1 in COLLECT: mask cleared and Fill_Count_Out=0 next cycle; Word_Out unchanged. A same-cycle write is discarded.
- Flush_In=1 in HOLD: Word_Valid_Out deasserted next cycle, return to COLLECT, word discarded.
- Flush_In also clears Dup_Error_Out.

## Timing
- Reset (Reset_n_In=0 at an edge) sets:
  - state COLLECT, mask 0, Word_Out 0
  - Word_Valid_Out 0, Fill_Count_Out 0, Dup_Error_Out 0, Drop_Count_Out 0
- Reset overrides Flush_In and writes. Mid-frame or mid-HOLD reset discards everything.
- Write latency is 1 cycle: a write at edge N is visible on Word_Out and Fill_Count_Out after edge N.
- Completing write at edge N: Word_Valid_Out=1 from edge N to the transfer edge.
- Word_Valid_Out, once high, must not fall without a transfer, Flush_In or reset.
- Minimum frame period is CHANNELS cycles; back-to-back frames are possible with Word_Ready_In held high.
- Fill_Count_Out reaches CHANNELS only while in HOLD.

## Configuration
- OVERFLOW_CNT_EN defined:
  - Drop_Count_Out is present.
  - It increments on each dropped write and saturates at 255.
  - It is cleared only by reset.
- OVERFLOW_CNT_EN undefined: the port and counter are absent; drops are silent.

## Test plan
- Reset, then write Select_In 0..31 with Channel_In bit = select[0] -> Word_Valid_Out=1 one cycle after the write to channel 31, Word_Out=32'hAAAA_AAAA, Fill_Count_Out=32.
- Complete a frame with Word_Ready_In=0 for 5 cycles while Enable_In=1 -> Busy_Out=1, Word_Out stable, Drop_Count_Out=5; raise ready -> transfer, Fill_Count_Out=0.
- Write channel 7 twice (1 then 0) in one frame -> Dup_Error_Out=1, Fill_Count_Out unchanged by the second write, Word_Out[7]=0.
- Ready high, with a write to channel 3 in the transfer cycle -> new frame Fill_Count_Out=1 and Word_Valid_Out=0 in the next cycle.
- After 10 writes assert Flush_In -> Fill_Count_Out=0, Dup_Error_Out=0; then 32 writes are needed for Word_Valid_Out.
- Assert Reset_n_In=0 in HOLD -> next cycle all outputs 0, state COLLECT.
